mccpu: RTL and testbench

Multi-cycle MIPS-subset core, the successor to the single-cycle CPU top. It replaces the separate instruction/data ports with one shared, handshaked memory port, so the memory may insert any number of wait states. The reset vector is parametrised, and a halt state is entered on illegal or misaligned operations. It sits between the board-level memory/bus and the debug register viewer.

---
 rtl/mccpu_if.sv | 25 ++
 rtl/mccpu.sv | 193 +++++++++++++++++++
 tb/tb_mccpu.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccpu_if.sv
// mccpu_if: shared instruction/data memory port of the multi-cycle core.
//   mem_req   - transaction request (master -> slave)
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - word-aligned byte address
//   mem_wdata - store data
//   mem_rdata - read data, valid while mem_ready=1
//   mem_ready - completes the current request
interface mccpu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-subset core with one shared, handshaked memory port.
//   clk      - clock, all state on rising edge
//   rst      - asynchronous active-low reset
//   bus      - memory port (mccpu_if.master)
//   PC       - address of the instruction in flight
//   retire   - one-cycle pulse in the final state cycle of an instruction
//   halted   - core is stopped in HALT (illegal op or misaligned access)
//   reg_sel  - debug register select
//   reg_data - combinational GPR[reg_sel], $0 reads 0
//
// state    | meaning
// S_IDLE   | one cycle after reset before the first fetch
// S_FETCH  | read instruction at PC, wait for mem_ready
// S_DECODE | latch A/B operands, reject illegal encodings
// S_EXEC   | ALU op; branches and jumps complete here
// S_MEM    | lw/sw data access, wait for mem_ready
// S_WB     | register write-back, PC update
// S_HALT   | absorbing stop state, left only by reset
module mccpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    mccpu_if.master        bus,
    output logic [31:0]    PC,
    output logic           retire,
    output logic           halted,
    input  logic [4:0]     reg_sel,
    output logic [31:0]    reg_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] F_JR  = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR   = 6'h25, F_SLT  = 6'h2A;

    state_t      state, state_nxt;
    logic [31:0] ir, a_q, b_q, alu_out, mdr;
    logic [31:0] gpr [32];
    logic [31:0] pc_nxt, alu_res, wb_data;
    logic        gpr_we, legal;
    logic [4:0]  wb_dest;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, zext_imm, pc_plus4, br_target, j_target;

    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign funct     = ir[5:0];
    assign sext_imm  = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm  = {16'h0000, ir[15:0]};
    assign pc_plus4  = PC + 32'd4;
    assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir[25:0], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (funct == F_ADDU) || (funct == F_SUBU) || (funct == F_AND) ||
                              (funct == F_OR)   || (funct == F_SLT)  || (funct == F_JR);
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU:  alu_res = a_q + b_q;
                    F_SUBU:  alu_res = a_q - b_q;
                    F_AND:   alu_res = a_q & b_q;
                    F_OR:    alu_res = a_q | b_q;
                    F_SLT:   alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
                    default: alu_res = 32'h0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + sext_imm;
            OP_ANDI: alu_res = a_q & zext_imm;
            OP_ORI:  alu_res = a_q | zext_imm;
            OP_LUI:  alu_res = {ir[15:0], 16'h0000};
            OP_JAL:  alu_res = pc_plus4;
            default: alu_res = 32'h0;
        endcase
    end

    assign wb_dest = (opcode == OP_RTYPE) ? rd : ((opcode == OP_JAL) ? 5'd31 : rt);
    assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        retire    = 1'b0;
        gpr_we    = 1'b0;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (opcode)
                    OP_BEQ: begin
                        pc_nxt    = (a_q == b_q) ? br_target : pc_plus4;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_J: begin
                        pc_nxt    = j_target;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_LW, OP_SW: state_nxt = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                    OP_RTYPE: begin
                        if (funct == F_JR) begin
                            if (a_q[1:0] != 2'b00) begin
                                state_nxt = S_HALT;
                            end else begin
                                pc_nxt    = a_q;
                                retire    = 1'b1;
                                state_nxt = S_FETCH;
                            end
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_nxt    = pc_plus4;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                gpr_we    = 1'b1;
                pc_nxt    = (opcode == OP_JAL) ? j_target : pc_plus4;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            PC      <= RESET_PC;
            ir      <= 32'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
            if (state == S_FETCH && bus.mem_ready) ir <= bus.mem_rdata;
            if (state == S_DECODE) begin
                a_q <= gpr[rs];
                b_q <= gpr[rt];
            end
            if (state == S_EXEC) alu_out <= alu_res;
            if (state == S_MEM && bus.mem_ready) mdr <= bus.mem_rdata;
            // $0 is never written, so it stays at its reset value of zero
            if (gpr_we && wb_dest != 5'd0) gpr[wb_dest] <= wb_data;
        end
    end

    // Address/data are pure functions of held registers, so they stay stable
    // for the whole request and fall to zero as soon as reset forces IDLE.
    assign bus.mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign bus.mem_we    = (state == S_MEM) && (opcode == OP_SW);
    assign bus.mem_addr  = (state == S_FETCH) ? PC : ((state == S_MEM) ? alu_out : 32'h0);
    assign bus.mem_wdata = bus.mem_we ? b_q : 32'h0;
    assign halted        = (state == S_HALT);
    assign reg_data      = (reg_sel == 5'd0) ? 32'h0 : gpr[reg_sel];
endmodule

// File: tb/tb_mccpu.sv
module tb_mccpu;
    localparam logic [31:0] RST_VEC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        retire, halted;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    mccpu_if bus();

    mccpu #(.RESET_PC(RST_VEC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .PC(pc), .retire(retire),
        .halted(halted), .reg_sel(reg_sel), .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] gap; } ret_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } st_t;

    ret_t ret_q[$];
    st_t  st_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_ret = 0;
    int   data_wait = 0;
    int   wcnt = 0;
    logic [31:0] mem [int];

    logic        prev_req = 1'b0, prev_hs = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(int'(a[31:2]))) return mem[int'(a[31:2])];
        return 32'h0;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] w);
        mem[int'(a[31:2])] = w;
    endtask

    task automatic exp_ret(input logic [31:0] p, input int g);
        ret_t e;
        e.pc  = p;
        e.gap = 32'(g);
        ret_q.push_back(e);
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a;
        s.data = d;
        st_q.push_back(s);
    endtask

    task automatic start_cpu();
        @(negedge clk);
        rst = 1'b1;
        last_ret = cyc;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int i = 0;
        while (!halted && i < budget) begin
            @(negedge clk); #2;
            i++;
        end
        check(name, 32'(halted), 32'h1);
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (ret_q.size() != 0 && i < budget) begin
            @(negedge clk); #2;
            i++;
        end
        check(name, 32'(ret_q.size()), 32'h0);
        ret_q.delete();
    endtask

    task automatic no_req(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #2;
            check(name, 32'(bus.mem_req), 32'h0);
        end
    endtask

    task automatic chk_reg(input string name, input logic [4:0] sel, input logic [31:0] exp);
        reg_sel = sel;
        #1;
        check(name, reg_data, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: fetches (addr >= RST_VEC) are zero-wait, data
    // accesses take data_wait extra cycles.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (wcnt >= ((bus.mem_addr < RST_VEC) ? data_wait : 0)) begin
                    bus.mem_ready = 1'b1;
                    wcnt = 0;
                    if (bus.mem_we) load(bus.mem_addr, bus.mem_wdata);
                    else bus.mem_rdata = rd_mem(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: pops expected retires and stores, checks request stability.
    initial begin
        ret_t e;
        st_t  s;
        forever begin
            @(negedge clk); #1;
            if (prev_req && !prev_hs && bus.mem_req) begin
                check("hold_addr", bus.mem_addr, prev_addr);
                check("hold_we", 32'(bus.mem_we), 32'(prev_we));
                check("hold_wdata", bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
                if (st_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL store_unexpected: got addr %h data %h expected no store",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    s = st_q.pop_front();
                    check("store_addr", bus.mem_addr, s.addr);
                    check("store_data", bus.mem_wdata, s.data);
                end
            end
            if (retire) begin
                if (ret_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL retire_unexpected: got retire at pc %h expected none", pc);
                end else begin
                    e = ret_q.pop_front();
                    check("retire_pc", pc, e.pc);
                    check("retire_gap", 32'(cyc - last_ret), e.gap);
                end
                last_ret = cyc;
            end
            prev_req   = bus.mem_req;
            prev_hs    = bus.mem_req && bus.mem_ready;
            prev_we    = bus.mem_we;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        rst = 1'b1;
        reg_sel = 5'd0;
        #1 rst = 1'b0;

        // ---- program 1: ALU ops, sw/lw, jal, beq not taken, ends on illegal op
        load(32'h3000, enc_i(6'h08, 5'd0, 5'd1, 16'd5));        // addi $1,$0,5
        load(32'h3004, enc_r(5'd1, 5'd1, 5'd2, 6'h21));         // addu $2,$1,$1
        load(32'h3008, enc_i(6'h2B, 5'd0, 5'd2, 16'd4));        // sw $2,4($0)
        load(32'h300C, enc_i(6'h23, 5'd0, 5'd3, 16'd4));        // lw $3,4($0)
        load(32'h3010, enc_j(6'h03, 32'h3020));                 // jal 0x3020
        load(32'h3020, enc_i(6'h04, 5'd1, 5'd2, 16'd5));        // beq $1,$2,+5
        load(32'h3024, enc_r(5'd1, 5'd2, 5'd4, 6'h23));         // subu $4,$1,$2
        load(32'h3028, enc_r(5'd4, 5'd1, 5'd5, 6'h2A));         // slt $5,$4,$1
        load(32'h302C, enc_i(6'h0F, 5'd0, 5'd6, 16'h1234));     // lui $6,0x1234
        load(32'h3030, enc_i(6'h0D, 5'd6, 5'd6, 16'h8765));     // ori $6,$6,0x8765
        load(32'h3034, enc_i(6'h0C, 5'd6, 5'd7, 16'hFF00));     // andi $7,$6,0xFF00
        load(32'h3038, enc_r(5'd1, 5'd2, 5'd8, 6'h25));         // or $8,$1,$2
        load(32'h303C, enc_r(5'd6, 5'd1, 5'd9, 6'h24));         // and $9,$6,$1
        load(32'h3040, enc_r(5'd1, 5'd1, 5'd0, 6'h21));         // addu $0,$1,$1
        load(32'h3044, enc_j(6'h02, 32'h3050));                 // j 0x3050
        load(32'h3050, 32'hFC00_0000);                          // opcode 0x3F

        exp_ret(32'h3000, 4); exp_ret(32'h3004, 4); exp_ret(32'h3008, 4);
        exp_ret(32'h300C, 5); exp_ret(32'h3010, 4); exp_ret(32'h3020, 3);
        exp_ret(32'h3024, 4); exp_ret(32'h3028, 4); exp_ret(32'h302C, 4);
        exp_ret(32'h3030, 4); exp_ret(32'h3034, 4); exp_ret(32'h3038, 4);
        exp_ret(32'h303C, 4); exp_ret(32'h3040, 4); exp_ret(32'h3044, 3);
        exp_st(32'h4, 32'd10);

        repeat (3) @(negedge clk);
        #2;
        check("rst_req", 32'(bus.mem_req), 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_retire", 32'(retire), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_pc", pc, RST_VEC);

        start_cpu();
        #2;
        check("idle_req", 32'(bus.mem_req), 32'h0);
        @(negedge clk); #2;
        check("first_req", 32'(bus.mem_req), 32'h1);
        check("first_addr", bus.mem_addr, RST_VEC);
        check("first_we", 32'(bus.mem_we), 32'h0);

        wait_halt("p1_halted", 400);
        check("p1_halt_pc", pc, 32'h3050);
        drain("p1_drain", 5);
        chk_reg("r1", 5'd1, 32'd5);
        chk_reg("r2", 5'd2, 32'd10);
        chk_reg("r3_lw", 5'd3, 32'd10);
        chk_reg("r4_subu", 5'd4, 32'hFFFF_FFFB);
        chk_reg("r5_slt", 5'd5, 32'd1);
        chk_reg("r6_lui_ori", 5'd6, 32'h1234_8765);
        chk_reg("r7_andi", 5'd7, 32'h0000_8700);
        chk_reg("r8_or", 5'd8, 32'd15);
        chk_reg("r9_and", 5'd9, 32'd5);
        chk_reg("r0", 5'd0, 32'd0);
        chk_reg("r31_jal", 5'd31, 32'h3014);
        no_req("p1_halt_noreq", 8);
        check("p1_halt_pc_hold", pc, 32'h3050);

        rst = 1'b0;
        #1;
        check("p1_rst_halted", 32'(halted), 32'h0);
        check("p1_rst_pc", pc, RST_VEC);
        chk_reg("p1_rst_gpr", 5'd2, 32'd0);

        // ---- program 2: lw/sw with 3 data wait states, beq taken -1 loop
        mem.delete();
        data_wait = 3;
        load(32'h8, 32'hDEAD_BEEF);
        load(32'h3000, enc_i(6'h23, 5'd0, 5'd3, 16'd8));        // lw $3,8($0)
        load(32'h3004, enc_i(6'h2B, 5'd0, 5'd3, 16'd12));       // sw $3,12($0)
        load(32'h3008, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));     // beq $0,$0,-1
        exp_ret(32'h3000, 8);
        exp_ret(32'h3004, 7);
        exp_ret(32'h3008, 3);
        exp_ret(32'h3008, 3);
        exp_st(32'hC, 32'hDEAD_BEEF);
        start_cpu();
        drain("p2_drain", 200);
        chk_reg("p2_r3", 5'd3, 32'hDEAD_BEEF);
        rst = 1'b0;
        check("p2_store_drain", 32'(st_q.size()), 32'h0);

        // ---- program 3: misaligned lw halts
        mem.delete();
        data_wait = 0;
        load(32'h3000, enc_i(6'h23, 5'd0, 5'd1, 16'd2));        // lw $1,2($0)
        start_cpu();
        wait_halt("p3_halted", 50);
        check("p3_pc", pc, 32'h3000);
        no_req("p3_noreq", 6);
        chk_reg("p3_r1", 5'd1, 32'd0);
        rst = 1'b0;

        // ---- program 4: jr to misaligned target halts
        mem.delete();
        load(32'h3000, enc_i(6'h08, 5'd0, 5'd1, 16'h3001));     // addi $1,$0,0x3001
        load(32'h3004, enc_r(5'd1, 5'd0, 5'd0, 6'h08));         // jr $1
        exp_ret(32'h3000, 4);
        start_cpu();
        wait_halt("p4_halted", 50);
        check("p4_pc", pc, 32'h3004);
        drain("p4_drain", 5);
        no_req("p4_noreq", 6);
        rst = 1'b0;
        #1;
        check("p4_rst_halted", 32'(halted), 32'h0);

        // ---- program 5: reset during a lw wait state
        mem.delete();
        data_wait = 3;
        load(32'h8, 32'd99);
        load(32'h3000, enc_i(6'h08, 5'd0, 5'd1, 16'd7));        // addi $1,$0,7
        load(32'h3004, enc_i(6'h23, 5'd0, 5'd1, 16'd8));        // lw $1,8($0)
        exp_ret(32'h3000, 4);
        start_cpu();
        i = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h8) && i < 50) begin
            @(negedge clk); #2;
            i++;
        end
        check("p5_mem_wait_seen", 32'(bus.mem_req && bus.mem_addr == 32'h8), 32'h1);
        check("p5_ready_low", 32'(bus.mem_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("p5_req_drop", 32'(bus.mem_req), 32'h0);
        check("p5_pc", pc, RST_VEC);
        chk_reg("p5_r1", 5'd1, 32'd0);
        drain("p5_drain", 5);
        start_cpu();
        #2;
        check("p5_idle_req", 32'(bus.mem_req), 32'h0);
        @(negedge clk); #2;
        check("p5_restart_req", 32'(bus.mem_req), 32'h1);
        check("p5_restart_addr", bus.mem_addr, RST_VEC);
        rst = 1'b0;
        @(negedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
